regfile_mp_scoreboard: RTL and testbench

- Parametrised multi-port integer register file, successor to the single-write/dual-read GPR file.
- Adds:
  - N read ports and M write ports.
  - Synchronous clear.
  - Optional same-cycle write-to-read bypass.
  - Per-register busy scoreboard.
- Sits between decode/issue, which reads operands and marks destinations busy, and writeback, which writes results and clears busy.

---
 rtl/regfile_mp_scoreboard.sv | 63 ++++++
 tb/tb_regfile_mp_scoreboard.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_scoreboard.sv
// regfile_mp_scoreboard: multi-port register file with write bypass and per-register busy scoreboard
module regfile_mp_scoreboard #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NWR-1:0]      wr_clr,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd,
  output logic [NREG-1:0]     busy_vec
);
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d, clr, iss_set;
  always_comb begin
    regs_d  = regs_q;
    clr     = '0;
    iss_set = '0;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && wr_addr[j*AW +: AW] != '0) begin
        regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
        clr[wr_addr[j*AW +: AW]]    = clr[wr_addr[j*AW +: AW]] | wr_clr[j];
      end
    end
    if (iss_en) iss_set[iss_rd] = 1'b1;
    busy_d    = iss_set | (busy_q & ~clr);
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end
  assign busy_vec = busy_q;
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rdat;
    assign ra = rd_addr[i*AW +: AW];
    // later ports overwrite earlier ones so the highest-index writer wins
    always_comb begin
      rdat = regs_q[ra];
      for (int j = 0; j < NWR; j++)
        if (BYPASS != 0 && wr_en[j] && wr_addr[j*AW +: AW] == ra) rdat = wr_data[j*XLEN +: XLEN];
    end
    assign rd_data[i*XLEN +: XLEN] = (ra == '0) ? '0 : rdat;
    assign rd_busy[i] = (BYPASS != 0) ? busy_q[ra] & ~clr[ra] : busy_q[ra];
  end
endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// tb_regfile_mp_scoreboard: directed checks of the register file with and without write bypass
module tb_regfile_mp_scoreboard;
  logic         clk = 1'b0;
  logic         rst;
  logic [9:0]   rd_addr;
  logic [127:0] rd_data, rd_data_nb;
  logic [1:0]   rd_busy, rd_busy_nb;
  logic [1:0]   wr_en, wr_clr;
  logic [9:0]   wr_addr;
  logic [127:0] wr_data;
  logic         iss_en;
  logic [4:0]   iss_rd;
  logic [31:0]  busy_vec, busy_vec_nb;
  logic [31:0]  exp_busy;
  int n_chk = 0;
  int n_fail = 0;

  regfile_mp_scoreboard dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
    .iss_en(iss_en), .iss_rd(iss_rd), .busy_vec(busy_vec)
  );

  regfile_mp_scoreboard #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
    .iss_en(iss_en), .iss_rd(iss_rd), .busy_vec(busy_vec_nb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = '0;
    wr_clr = '0;
    iss_en = 1'b0;
  endtask

  task automatic wr(input int j, input logic [4:0] a, input logic [63:0] d, input logic c);
    wr_en[j]           = 1'b1;
    wr_addr[j*5 +: 5]  = a;
    wr_data[j*64 +: 64] = d;
    wr_clr[j]          = c;
  endtask

  initial begin
    rst = 1'b1; rd_addr = '0; wr_addr = '0; wr_data = '0; iss_rd = '0;
    idle();
    tick();
    rst = 1'b0;
    chk("reset_rd0", rd_data[63:0], 64'h0);
    chk("reset_busy", busy_vec, 32'h0);
    chk("reset_rdbusy", {62'h0, rd_busy}, 64'h0);
    wr(0, 5'd5, 64'h1234_5678_9ABC_DEF0, 1'b0);
    tick();
    idle();
    rd_addr = {5'd0, 5'd5};
    #1;
    chk("x5_read", rd_data[63:0], 64'h1234_5678_9ABC_DEF0);
    chk("x0_read", rd_data[127:64], 64'h0);
    chk("x5_read_nb", rd_data_nb[63:0], 64'h1234_5678_9ABC_DEF0);
    wr(1, 5'd0, 64'hFFFF, 1'b0);
    iss_en = 1'b1; iss_rd = 5'd0;
    #1;
    chk("x0_bypass", rd_data[127:64], 64'h0);
    tick();
    idle();
    chk("x0_after_wr", rd_data[127:64], 64'h0);
    chk("x0_busy_vec", busy_vec, 32'h0);
    chk("x0_rdbusy", {63'h0, rd_busy[1]}, 64'h0);
    rd_addr = {5'd0, 5'd7};
    wr(0, 5'd7, 64'hAA, 1'b0);
    #1;
    chk("x7_bypass", rd_data[63:0], 64'hAA);
    chk("x7_nobypass_old", rd_data_nb[63:0], 64'h0);
    tick();
    idle();
    chk("x7_nobypass_new", rd_data_nb[63:0], 64'hAA);
    rd_addr = {5'd3, 5'd7};
    wr(0, 5'd3, 64'h11, 1'b0);
    wr(1, 5'd3, 64'h22, 1'b0);
    #1;
    chk("x3_conflict_bypass", rd_data[127:64], 64'h22);
    chk("x3_conflict_nb_old", rd_data_nb[127:64], 64'h0);
    tick();
    idle();
    chk("x3_conflict_stored", rd_data[127:64], 64'h22);
    chk("x3_conflict_stored_nb", rd_data_nb[127:64], 64'h22);
    rd_addr = {5'd3, 5'd9};
    iss_en = 1'b1; iss_rd = 5'd9;
    #1;
    chk("iss_no_bypass", {63'h0, rd_busy[0]}, 64'h0);
    tick();
    idle();
    chk("iss_busy_vec", busy_vec, 32'h0000_0200);
    chk("iss_rdbusy", {63'h0, rd_busy[0]}, 64'h1);
    chk("iss_rdbusy_other", {63'h0, rd_busy[1]}, 64'h0);
    wr(0, 5'd9, 64'h99, 1'b1);
    #1;
    chk("clr_rdbusy_bypass", {63'h0, rd_busy[0]}, 64'h0);
    chk("clr_rdbusy_nb", {63'h0, rd_busy_nb[0]}, 64'h1);
    chk("clr_busy_vec_same", busy_vec, 32'h0000_0200);
    tick();
    idle();
    chk("clr_busy_vec_next", busy_vec, 32'h0);
    chk("clr_data", rd_data[63:0], 64'h99);
    iss_en = 1'b1; iss_rd = 5'd9;
    tick();
    idle();
    chk("reissue", busy_vec, 32'h0000_0200);
    iss_en = 1'b1; iss_rd = 5'd9;
    wr(1, 5'd9, 64'h9A, 1'b1);
    #1;
    chk("iss_clr_rdbusy", {63'h0, rd_busy[0]}, 64'h0);
    tick();
    idle();
    chk("iss_clr_busy_vec", busy_vec, 32'h0000_0200);
    wr_clr[0] = 1'b1; wr_addr[4:0] = 5'd9;
    tick();
    idle();
    chk("clr_without_en", busy_vec, 32'h0000_0200);
    wr(0, 5'd9, 64'h9B, 1'b0);
    tick();
    idle();
    chk("wr_without_clr", busy_vec, 32'h0000_0200);
    chk("wr_without_clr_data", rd_data[63:0], 64'h9B);
    exp_busy = '0;
    for (int r = 1; r < 32; r++) begin
      wr(0, r[4:0], 64'h100 + 64'(r), 1'b0);
      iss_en = (r % 3 == 0);
      iss_rd = r[4:0];
      if (r % 3 == 0) exp_busy[r] = 1'b1;
      tick();
    end
    idle();
    rd_addr = {5'd31, 5'd17};
    #1;
    chk("fill_x17", rd_data[63:0], 64'h111);
    chk("fill_x31", rd_data[127:64], 64'h11F);
    chk("fill_busy_vec", busy_vec, exp_busy);
    rst = 1'b1;
    wr(0, 5'd4, 64'hDEAD, 1'b0);
    iss_en = 1'b1; iss_rd = 5'd5;
    tick();
    rst = 1'b0;
    idle();
    chk("rst_busy_vec", busy_vec, 32'h0);
    chk("rst_busy_vec_nb", busy_vec_nb, 32'h0);
    for (int r = 0; r < 32; r += 2) begin
      rd_addr = {5'(r + 1), 5'(r)};
      #1;
      chk("rst_data_even", rd_data[63:0], 64'h0);
      chk("rst_data_odd", rd_data[127:64], 64'h0);
      chk("rst_data_nb", rd_data_nb, 128'h0);
      chk("rst_rdbusy", {62'h0, rd_busy}, 64'h0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
